// File: rtl/cnn_layer_accel_datain_arb_pkg.sv
// Shared definitions for the layer input-FIFO arbiter: state encodings,
// grant-type constants and width helpers.
package cnn_layer_accel_datain_arb_pkg;

  localparam logic [2:0] ST_ARB_IDLE  = 3'b001;
  localparam logic [2:0] ST_ARB_GRANT = 3'b010;
  localparam logic [2:0] ST_ARB_DRAIN = 3'b100;

  localparam logic GT_SEQ = 1'b1;
  localparam logic GT_PIX = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Index/counter width that never collapses to zero bits.
  function automatic int idx_w(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/cnn_layer_accel_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching modulo N (N need not be a power of two).
module cnn_layer_accel_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cnn_layer_accel_datain_arb.sv
// Round-robin arbiter sharing one FWFT input FIFO between the octo BRAM
// controllers; sequencer loads take priority over pixel loads.
module cnn_layer_accel_datain_arb
  import cnn_layer_accel_datain_arb_pkg::*;
#(
  parameter  int C_NUM_AWE   = 4,
  parameter  int C_MAX_BURST = 256,
  localparam int IDX_W       = idx_w(C_NUM_AWE),
  localparam int BURST_W     = idx_w(C_MAX_BURST)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  output logic                 fifo_rden,
  input  logic [C_NUM_AWE-1:0] seq_req,
  input  logic [C_NUM_AWE-1:0] pix_req,
  input  logic [C_NUM_AWE-1:0] seq_datain_rdy,
  input  logic [C_NUM_AWE-1:0] pixel_datain_rdy,
  output logic [C_NUM_AWE-1:0] datain_valid,
  output logic [C_NUM_AWE-1:0] seq_datain_tag,
  output logic [C_NUM_AWE-1:0] pixel_datain_tag,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 grant_active
);

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic               grant_type_q, grant_type_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [IDX_W-1:0]     seq_idx, pix_idx;
  logic                 seq_found, pix_found;
  logic                 in_grant, req_g, rdy_g, pop, last_word;
  logic [C_NUM_AWE-1:0] onehot;

  cnn_layer_accel_rr_pick #(.N(C_NUM_AWE), .IDX_W(IDX_W)) u_pick_seq (
    .req   (seq_req),
    .ptr   (rr_ptr_q),
    .idx   (seq_idx),
    .found (seq_found)
  );

  cnn_layer_accel_rr_pick #(.N(C_NUM_AWE), .IDX_W(IDX_W)) u_pick_pix (
    .req   (pix_req),
    .ptr   (rr_ptr_q),
    .idx   (pix_idx),
    .found (pix_found)
  );

  // Output decode: only the grantee sees valid/tag, and only in GRANT.
  always_comb begin
    in_grant  = (state_q == ST_ARB_GRANT);
    req_g     = (grant_type_q == GT_SEQ) ? seq_req[grant_id_q] : pix_req[grant_id_q];
    rdy_g     = (grant_type_q == GT_SEQ) ? seq_datain_rdy[grant_id_q]
                                         : pixel_datain_rdy[grant_id_q];
    onehot    = in_grant ? (C_NUM_AWE'(1) << grant_id_q) : '0;
    pop       = in_grant & ~fifo_empty & rdy_g & ~rst;
    last_word = (burst_cnt_q == BURST_W'(C_MAX_BURST - 1));

    datain_valid     = fifo_empty ? '0 : onehot;
    seq_datain_tag   = (grant_type_q == GT_SEQ) ? onehot : '0;
    pixel_datain_tag = (grant_type_q == GT_PIX) ? onehot : '0;
    fifo_rden        = pop;
    grant_id         = grant_id_q;
    grant_active     = in_grant;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    grant_type_d = grant_type_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      ST_ARB_IDLE: begin
        if (seq_found) begin
          grant_id_d   = seq_idx;
          grant_type_d = GT_SEQ;
          burst_cnt_d  = '0;
          state_d      = ST_ARB_GRANT;
        end else if (pix_found) begin
          grant_id_d   = pix_idx;
          grant_type_d = GT_PIX;
          burst_cnt_d  = '0;
          state_d      = ST_ARB_GRANT;
        end
      end
      ST_ARB_GRANT: begin
        if (pop) burst_cnt_d = burst_cnt_q + 1'b1;
        // A word popped alongside a request drop still counts; then drain.
        if (!req_g || (pop && last_word)) begin
          rr_ptr_d = (grant_id_q == IDX_W'(C_NUM_AWE - 1)) ? '0 : grant_id_q + 1'b1;
          state_d  = ST_ARB_DRAIN;
        end
      end
      ST_ARB_DRAIN: state_d = ST_ARB_IDLE;
      default:      state_d = ST_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ARB_IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      grant_type_q <= GT_PIX;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      grant_type_q <= grant_type_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_datain_arb.sv
// Randomized bench for the datain arbiter: a grant-level reference model feeds
// an expected-output queue that a separate monitor drains each cycle.
module tb_cnn_layer_accel_datain_arb;

  localparam int N  = 4;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_empty;
  logic         fifo_rden;
  logic [N-1:0] seq_req, pix_req, seq_rdy, pix_rdy;
  logic [N-1:0] dv, st, pt;
  logic [1:0]   gid;
  logic         act;

  always #5 clk = ~clk;

  cnn_layer_accel_datain_arb #(.C_NUM_AWE(N), .C_MAX_BURST(MB)) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_empty       (fifo_empty),
    .fifo_rden        (fifo_rden),
    .seq_req          (seq_req),
    .pix_req          (pix_req),
    .seq_datain_rdy   (seq_rdy),
    .pixel_datain_rdy (pix_rdy),
    .datain_valid     (dv),
    .seq_datain_tag   (st),
    .pixel_datain_tag (pt),
    .grant_id         (gid),
    .grant_active     (act)
  );

  typedef struct packed {
    logic [N-1:0] v;
    logic [N-1:0] st;
    logic [N-1:0] pt;
    logic         rden;
    logic [1:0]   gid;
    logic         act;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   empty_viol  = 0;
  bit   stim_done   = 1'b0;

  // Reference model: who holds the stream, how many words it has taken,
  // and whether the one-cycle post-grant gap is pending.
  bit m_busy, m_gap, m_seq;
  int m_owner, m_words, m_ptr;

  function automatic exp_t predict();
    exp_t e;
    e     = '0;
    e.gid = 2'(m_owner);
    if (m_busy) begin
      e.act = 1'b1;
      if (!fifo_empty) e.v[m_owner] = 1'b1;
      if (m_seq) e.st[m_owner] = 1'b1;
      else       e.pt[m_owner] = 1'b1;
      e.rden = !fifo_empty && !rst && (m_seq ? seq_rdy[m_owner] : pix_rdy[m_owner]);
    end
    return e;
  endfunction

  task automatic model_step(input exp_t e);
    bit found;
    bit r;
    int i;
    if (rst) begin
      m_busy = 0; m_gap = 0; m_seq = 0; m_owner = 0; m_words = 0; m_ptr = 0;
    end else if (m_busy) begin
      if (e.rden) m_words++;
      if (!(m_seq ? seq_req[m_owner] : pix_req[m_owner]) || (e.rden && m_words == MB)) begin
        m_busy = 0;
        m_gap  = 1;
        m_ptr  = (m_owner + 1) % N;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      found = 0;
      for (int pass = 0; pass < 2; pass++) begin
        for (int k = 0; k < N; k++) begin
          i = (m_ptr + k) % N;
          r = (pass == 0) ? seq_req[i] : pix_req[i];
          if (!found && r) begin
            found   = 1;
            m_owner = i;
            m_seq   = (pass == 0);
          end
        end
      end
      if (found) begin
        m_busy  = 1;
        m_words = 0;
      end
    end
  endtask

  initial begin
    exp_t         e, prev;
    bit           will;
    logic [N-1:0] stray_s, stray_p;
    rst = 1'b1; fifo_empty = 1'b1;
    seq_req = '0; pix_req = '0; seq_rdy = '0; pix_rdy = '0;
    m_busy = 0; m_gap = 0; m_seq = 0; m_owner = 0; m_words = 0; m_ptr = 0;
    prev = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = (cyc < 3) || (cyc > 250 && $urandom_range(0, 299) == 0);
      if (cyc < 200) begin
        // All pixel requesters, FIFO full, controllers always accept.
        seq_req    = '0;
        pix_req    = '1;
        fifo_empty = 1'b0;
        seq_rdy    = prev.v & prev.st;
        pix_rdy    = prev.v & prev.pt;
      end else begin
        for (int b = 0; b < N; b++) begin
          if ($urandom_range(0, 19) == 0) seq_req[b] = ~seq_req[b];
          if ($urandom_range(0, 9) == 0)  pix_req[b] = ~pix_req[b];
        end
        fifo_empty = ($urandom_range(0, 2) == 0);
        will       = ($urandom_range(0, 3) != 0);
        stray_s    = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
        stray_p    = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
        seq_rdy    = (prev.v & prev.st & {N{will}}) | stray_s;
        pix_rdy    = (prev.v & prev.pt & {N{will}}) | stray_p;
      end
      e = predict();
      sbq.push_back(e);
      model_step(e);
      prev = e;
    end
    stim_done = 1'b1;
  end

  initial begin
    exp_t e, a;
    while (1) begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        a = {dv, st, pt, fifo_rden, gid, act};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL arb_outputs t=%0t got v=%b st=%b pt=%b rden=%b gid=%0d act=%b want v=%b st=%b pt=%b rden=%b gid=%0d act=%b",
                   $time, a.v, a.st, a.pt, a.rden, a.gid, a.act,
                   e.v, e.st, e.pt, e.rden, e.gid, e.act);
        end
        if (fifo_empty && (dv !== '0)) begin
          empty_viol++;
          $display("FAIL valid_while_empty t=%0t got v=%b want 0", $time, dv);
        end
      end
      if (stim_done && sbq.size() == 0) break;
    end
    if (vectors != 3000)
      $display("FAIL vector_count got %0d want 3000", vectors);
    if (miscompares != 0)
      $display("FAIL miscompare_total got %0d want 0", miscompares);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + empty_viol);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got %0d vectors want 3000", vectors);
    $fatal(1, "watchdog");
  end

endmodule
